// File: rtl/apb_cmd_master.sv
// APB initiator: single-beat valid/ready commands become APB SETUP/ACCESS transfers,
// with a registered valid/ready response and an optional ACCESS-phase timeout.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | PSEL high, PENABLE low, one cycle only
// ACCESS | PSEL and PENABLE high, waiting for PREADY or timeout
// RESP   | rsp_valid high, waiting for rsp_ready
module apb_cmd_master #(
  parameter int AW      = 12,
  parameter int TIMEOUT = 256
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic          cmd_write,
  input  logic [31:0]   cmd_wdata,
  input  logic [3:0]    cmd_strb,
  input  logic [2:0]    cmd_prot,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic [31:0]   PWDATA,
  output logic [3:0]    PSTRB,
  output logic [2:0]    PPROT,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          APBACTIVE,
  input  logic [31:0]   PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN  = (TIMEOUT != 0);
  localparam logic [CW-1:0] TC     = TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pstrb_q, pstrb_d;
  logic [2:0]    pprot_q, pprot_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          to_q, to_d;
  logic [CW-1:0] tcnt_q, tcnt_d;

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pprot_d  = pprot_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    to_d     = to_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : 4'h0;
          pprot_d  = cmd_prot;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        tcnt_d  = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // PREADY wins over a timeout landing in the same cycle
        if (PREADY) begin
          rdata_d = pwrite_q ? 32'h0 : PRDATA;
          err_d   = PSLVERR;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (TO_EN && (tcnt_q == TC)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = S_RESP;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      pstrb_q  <= pstrb_d;
      pprot_q  <= pprot_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      to_q     <= to_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && !reset;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;
  assign PSTRB       = pstrb_q;
  assign PPROT       = pprot_q;
  assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign PENABLE     = (state_q == S_ACCESS);
  assign APBACTIVE   = (state_q != S_IDLE);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed table, hand-written reset-abort sequence and
// randomized commands checked against a transfer-level reference model.
module tb_apb_cmd_master;
  localparam int AW  = 12;
  localparam int TMO = 8;

  logic          pclk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_strb;
  logic [2:0]    cmd_prot;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PSEL, PENABLE, APBACTIVE, PREADY, PSLVERR;
  logic [31:0]   PWDATA, PRDATA;
  logic [3:0]    PSTRB;
  logic [2:0]    PPROT;

  apb_cmd_master #(.AW(AW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
    .PSEL(PSEL), .PENABLE(PENABLE), .APBACTIVE(APBACTIVE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;   // PREADY-low ACCESS cycles before PREADY
    bit          slverr;
    logic [31:0] prdata;
    int          rdly;    // cycles rsp_ready stays low
    bit          hold;    // keep cmd_valid high while busy
    logic [31:0] e_rdata;
    bit          e_err;
    bit          e_to;
    int          e_acc;   // expected ACCESS cycles
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input logic [2:0] prot, input int waits,
                              input bit slverr, input logic [31:0] prdata, input int rdly,
                              input bit hold, input logic [31:0] e_rdata, input bit e_err,
                              input bit e_to, input int e_acc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
    v.waits = waits; v.slverr = slverr; v.prdata = prdata; v.rdly = rdly; v.hold = hold;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_to = e_to; v.e_acc = e_acc;
    return v;
  endfunction

  // Transfer-level reference: a slave that never answers within TMO cycles times out.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.e_to    = (v.waits >= TMO);
    r.e_acc   = r.e_to ? TMO : v.waits + 1;
    r.e_err   = r.e_to | v.slverr;
    r.e_rdata = (r.e_to || v.wr) ? 32'h0 : v.prdata;
    return r;
  endfunction

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_cmd(input vec_t v);
    int  cyc;
    int  acc;
    bit  done;
    logic [3:0] e_strb;
    e_strb    = v.wr ? v.strb : 4'h0;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_strb  = v.strb;
    cmd_prot  = v.prot;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0;
    cyc = 1;
    chk("setup_psel_penable", {PSEL, PENABLE}, 2'b10);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwrite", PWRITE, v.wr);
    chk("setup_pwdata", PWDATA, v.wdata);
    chk("setup_pstrb", PSTRB, e_strb);
    chk("setup_pprot", PPROT, v.prot);
    chk("setup_apbactive", APBACTIVE, 1);
    chk("setup_cmd_ready", cmd_ready, 0);
    acc  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      if (rsp_valid) begin
        done = 1;
      end else begin
        if (PSEL && PENABLE) begin
          chk("access_paddr", PADDR, v.addr);
          chk("access_pstrb", PSTRB, e_strb);
          PREADY  = (acc == v.waits);
          PSLVERR = PREADY ? v.slverr : 1'b0;
          PRDATA  = PREADY ? v.prdata : $urandom;
          acc++;
          #1 chk("rsp_valid_not_comb", rsp_valid, 0);
        end else begin
          PREADY  = 1'b0;
          PSLVERR = 1'b0;
        end
        @(negedge pclk);
        cyc++;
      end
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    if (!done) chk("rsp_valid_wait_expired", 0, 1);
    chk("latency", cyc, 2 + v.e_acc);
    chk("access_cycles", acc, v.e_acc);
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_err", rsp_err, v.e_err);
    chk("rsp_timeout", rsp_timeout, v.e_to);
    chk("resp_psel", {PSEL, PENABLE}, 2'b00);
    chk("resp_cmd_ready", cmd_ready, 0);
    for (int i = 0; i < v.rdly; i++) begin
      if (v.hold) begin
        cmd_valid = 1'b1;
        cmd_addr  = ~v.addr;
        cmd_wdata = $urandom;
        cmd_write = ~v.wr;
        cmd_strb  = ~v.strb;
        cmd_prot  = ~v.prot;
      end
      @(negedge pclk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_rdata", rsp_rdata, v.e_rdata);
      chk("stall_rsp_err", {rsp_err, rsp_timeout}, {v.e_err, v.e_to});
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_psel", PSEL, 0);
      chk("stall_paddr", PADDR, v.addr);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_apbactive", APBACTIVE, 0);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t rv;
    tbl[0] = mk(1, 12'h0C8, 32'hDEADBEEF, 4'hF, 3'd0,  0, 0, 32'hAAAA5555, 0, 0, 32'h0,        0, 0, 1);
    tbl[1] = mk(0, 12'h010, 32'h11111111, 4'hF, 3'd2,  3, 0, 32'h12345678, 0, 0, 32'h12345678, 0, 0, 4);
    tbl[2] = mk(0, 12'h020, 32'h0,        4'h3, 3'd1,  0, 1, 32'hCAFEF00D, 1, 0, 32'hCAFEF00D, 1, 0, 1);
    tbl[3] = mk(0, 12'h030, 32'h0,        4'h0, 3'd0, 20, 0, 32'h55555555, 0, 0, 32'h0,        1, 1, 8);
    tbl[4] = mk(0, 12'h040, 32'h0,        4'h0, 3'd4,  7, 0, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 0, 8);
    tbl[5] = mk(1, 12'h050, 32'h87654321, 4'hC, 3'd0, 20, 0, 32'h0,        2, 0, 32'h0,        1, 1, 8);
    tbl[6] = mk(1, 12'h7FC, 32'h01020304, 4'h5, 3'd7,  0, 0, 32'hFFFFFFFF, 5, 1, 32'h0,        0, 0, 1);
    tbl[7] = mk(0, 12'hFFF, 32'h0,        4'hF, 3'd3,  1, 0, 32'h89ABCDEF, 0, 0, 32'h89ABCDEF, 0, 0, 2);
    tbl[8] = mk(1, 12'h123, 32'h00C0FFEE, 4'hF, 3'd0,  2, 1, 32'h13579BDF, 0, 0, 32'h0,        1, 0, 3);

    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_psel_penable", {PSEL, PENABLE, APBACTIVE}, 3'b000);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_pstrb_pprot_pwrite", {PSTRB, PPROT, PWRITE}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset = 1'b0;
    @(negedge pclk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 9; i++) run_cmd(tbl[i]);

    // Reset while a read is wait-stated in ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h3A5; cmd_prot = 3'd2;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("abort_in_access", {PSEL, PENABLE}, 2'b11);
    reset = 1'b1;
    @(negedge pclk);
    chk("abort_psel_penable", {PSEL, PENABLE, APBACTIVE}, 3'b000);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_paddr", PADDR, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("abort_no_rsp", {rsp_valid, cmd_ready, PSEL}, 3'b010);
    end
    run_cmd(tbl[1]);

    for (int i = 0; i < 40; i++) begin
      rv.wr     = $urandom_range(0, 1) != 0;
      rv.addr   = 12'($urandom);
      rv.wdata  = $urandom;
      rv.strb   = 4'($urandom);
      rv.prot   = 3'($urandom);
      rv.waits  = int'($urandom_range(0, 11));
      rv.slverr = $urandom_range(0, 3) == 0;
      rv.prdata = $urandom;
      rv.rdly   = int'($urandom_range(0, 3));
      rv.hold   = 1'b0;
      run_cmd(model(rv));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
